// File: rtl/fact_sweep_ctrl.sv
// Sweeps a factorial unit over an operand range, checks each answer against a
// constant expected table and reports pass/fail, first failing operand and cause.
module fact_sweep_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  n_first,
  input  logic [3:0]  n_last,
  output logic        fact_go,
  output logic [3:0]  fact_in,
  input  logic        fact_done,
  input  logic        fact_error,
  input  logic [31:0] fact_result,
  output logic        busy,
  output logic        sweep_done,
  output logic        pass,
  output logic        fail,
  output logic [3:0]  fail_n,
  output logic [1:0]  fail_code,
  output logic [4:0]  pass_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, CHECK, RELEASE, FINISH} state_t;

  state_t             state;
  logic [4:0]         n_cur;
  logic [4:0]         n_end;
  logic [TMO_W-1:0]   tmo_cnt;
  logic signed [32:0] res_q;
  logic               err_q;
  logic               exp_err;
  logic               err_bad;
  logic               res_bad;
  logic               tmo_hit;

  function automatic logic [31:0] fact_table(input logic [3:0] n);
    case (n)
      4'd0, 4'd1: fact_table = 32'd1;
      4'd2:  fact_table = 32'd2;
      4'd3:  fact_table = 32'd6;
      4'd4:  fact_table = 32'd24;
      4'd5:  fact_table = 32'd120;
      4'd6:  fact_table = 32'd720;
      4'd7:  fact_table = 32'd5040;
      4'd8:  fact_table = 32'd40320;
      4'd9:  fact_table = 32'd362880;
      4'd10: fact_table = 32'd3628800;
      4'd11: fact_table = 32'd39916800;
      4'd12: fact_table = 32'd479001600;
      default: fact_table = 32'd0;
    endcase
  endfunction

  // Operands 13..15 overflow 32 bits, so only the error flag is meaningful there.
  assign exp_err = (n_cur >= 5'd13);
  assign err_bad = (err_q != exp_err);
  assign res_bad = !exp_err && (res_q[31:0] != fact_table(n_cur[3:0]));
  assign tmo_hit = (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES));

  // Datapath: loop operand and captured factorial response.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      n_cur <= {1'b0, n_first};
      n_end <= {1'b0, n_last};
    end else if (state == RELEASE && !fact_done && n_cur != n_end) begin
      n_cur <= n_cur + 5'd1;
    end
    if (state == WAIT_DONE && fact_done) begin
      res_q <= {1'b0, fact_result};
      err_q <= fact_error;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fact_go    <= 1'b0;
      fact_in    <= 4'd0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_n     <= 4'd0;
      fail_code  <= 2'b00;
      pass_count <= 5'd0;
      tmo_cnt    <= '0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fail       <= 1'b0;
            fail_n     <= 4'd0;
            fail_code  <= 2'b00;
            pass_count <= 5'd0;
            tmo_cnt    <= '0;
            if (n_first > n_last) begin
              pass       <= 1'b1;
              sweep_done <= 1'b1;
              busy       <= 1'b0;
              state      <= FINISH;
            end else begin
              pass  <= 1'b0;
              busy  <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          fact_in <= n_cur[3:0];
          fact_go <= 1'b1;
          tmo_cnt <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (fact_done) begin
            fact_go <= 1'b0;
            state   <= CHECK;
          end else if (tmo_hit) begin
            fact_go    <= 1'b0;
            fail       <= 1'b1;
            fail_code  <= 2'b11;
            fail_n     <= n_cur[3:0];
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            state      <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (err_bad || res_bad) begin
            fail       <= 1'b1;
            fail_code  <= err_bad ? 2'b10 : 2'b01;
            fail_n     <= n_cur[3:0];
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            state      <= FINISH;
          end else begin
            pass_count <= pass_count + 5'd1;
            tmo_cnt    <= '0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          // 5-bit compare lets n_last=15 end the loop instead of wrapping.
          if (!fact_done) begin
            if (n_cur == n_end) begin
              pass       <= 1'b1;
              sweep_done <= 1'b1;
              busy       <= 1'b0;
              state      <= FINISH;
            end else begin
              state <= ISSUE;
            end
          end else if (tmo_hit) begin
            fact_go    <= 1'b0;
            fail       <= 1'b1;
            fail_code  <= 2'b11;
            fail_n     <= n_cur[3:0];
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            state      <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_sweep_ctrl.sv
// Bench for fact_sweep_ctrl: behavioural factorial unit with fault modes,
// table of sweep vectors plus hand sequences for reset and start-ignore cases.
module tb_fact_sweep_ctrl;

  localparam int M_OK    = 0;
  localparam int M_BAD6  = 1;
  localparam int M_HANG5 = 2;
  localparam int M_ERR13 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n_first = 4'd0;
  logic [3:0]  n_last = 4'd0;
  logic        fact_go;
  logic [3:0]  fact_in;
  logic        fact_done = 1'b0;
  logic        fact_error = 1'b0;
  logic [31:0] fact_result = 32'd0;
  logic        busy, sweep_done, pass, fail;
  logic [3:0]  fail_n;
  logic [1:0]  fail_code;
  logic [4:0]  pass_count;

  int total = 0;
  int bad = 0;
  int mode = M_OK;
  int lat = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  int cur_go = 0;
  int max_go = 0;
  logic go_prev = 1'b0;

  fact_sweep_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .start(start), .n_first(n_first), .n_last(n_last),
    .fact_go(fact_go), .fact_in(fact_in), .fact_done(fact_done),
    .fact_error(fact_error), .fact_result(fact_result), .busy(busy),
    .sweep_done(sweep_done), .pass(pass), .fail(fail), .fail_n(fail_n),
    .fail_code(fail_code), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_fact(input logic [3:0] n);
    longint f = 1;
    for (int k = 2; k <= int'(n); k++) f = f * k;
    return f[31:0];
  endfunction

  // Factorial unit model: responds 3 cycles into a request, drops done after go falls.
  always @(negedge clk) begin
    if (!rst) begin
      fact_done = 1'b0;
      lat = 0;
    end else if (fact_go) begin
      if (!fact_done && !(mode == M_HANG5 && fact_in == 4'd5)) begin
        if (lat == 2) begin
          fact_done   = 1'b1;
          fact_result = model_fact(fact_in);
          fact_error  = (fact_in >= 4'd13);
          if (mode == M_BAD6 && fact_in == 4'd6) fact_result = 32'd719;
          if (mode == M_ERR13 && fact_in == 4'd13) fact_error = 1'b0;
        end else begin
          lat++;
        end
      end
    end else begin
      fact_done = 1'b0;
      lat = 0;
    end
  end

  always @(posedge clk) begin
    if (fact_go && !go_prev) go_cnt++;
    if (sweep_done) done_cnt++;
    cur_go = fact_go ? cur_go + 1 : 0;
    if (cur_go > max_go) max_go = cur_go;
    go_prev = fact_go;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    n_first = a;
    n_last  = b;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 600; i++) begin
      if (sweep_done) break;
      @(negedge clk);
    end
    if (i == 600) begin
      total++;
      bad++;
      $display("FAIL %s: sweep_done got none want pulse", nm);
    end
  endtask

  task automatic clear_stats();
    go_cnt = 0;
    done_cnt = 0;
    max_go = 0;
  endtask

  typedef struct {
    logic [3:0] nf;
    logic [3:0] nl;
    int         md;
    logic       ep;
    logic       ef;
    logic [1:0] ec;
    logic [3:0] efn;
    logic [4:0] ecnt;
    int         egos;
    int         go_lim;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'd3,  4'd12, M_OK,    1'b1, 1'b0, 2'b00, 4'd0,  5'd10, 10, 8};
    tbl[1] = '{4'd0,  4'd15, M_OK,    1'b1, 1'b0, 2'b00, 4'd0,  5'd16, 16, 8};
    tbl[2] = '{4'd4,  4'd8,  M_BAD6,  1'b0, 1'b1, 2'b01, 4'd6,  5'd2,  3,  8};
    tbl[3] = '{4'd5,  4'd7,  M_HANG5, 1'b0, 1'b1, 2'b11, 4'd5,  5'd0,  1,  22};
    tbl[4] = '{4'd9,  4'd4,  M_OK,    1'b1, 1'b0, 2'b00, 4'd0,  5'd0,  0,  0};
    tbl[5] = '{4'd12, 4'd13, M_ERR13, 1'b0, 1'b1, 2'b10, 4'd13, 5'd1,  2,  8};
    tbl[6] = '{4'd15, 4'd15, M_OK,    1'b1, 1'b0, 2'b00, 4'd0,  5'd1,  1,  8};

    repeat (3) @(negedge clk);
    chk("rst_go", fact_go, 0);
    chk("rst_in", fact_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_cnt", pass_count, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].md;
      clear_stats();
      pulse_start(tbl[i].nf, tbl[i].nl);
      if (tbl[i].nf <= tbl[i].nl) chk($sformatf("v%0d_busy", i), busy, 1);
      wait_done($sformatf("v%0d_wait", i));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_pass", i), pass, tbl[i].ep);
      chk($sformatf("v%0d_fail", i), fail, tbl[i].ef);
      chk($sformatf("v%0d_code", i), fail_code, tbl[i].ec);
      chk($sformatf("v%0d_fail_n", i), fail_n, tbl[i].efn);
      chk($sformatf("v%0d_count", i), pass_count, tbl[i].ecnt);
      chk($sformatf("v%0d_gos", i), go_cnt, tbl[i].egos);
      chk($sformatf("v%0d_dones", i), done_cnt, 1);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_go_off", i), fact_go, 0);
      chk($sformatf("v%0d_go_len_ok", i), (max_go <= tbl[i].go_lim), 1);
    end

    // Start pulses while busy and during the FINISH cycle must be ignored.
    mode = M_OK;
    clear_stats();
    pulse_start(4'd2, 4'd4);
    repeat (3) @(negedge clk);
    pulse_start(4'd0, 4'd0);
    wait_done("ign_wait");
    n_first = 4'd1;
    n_last  = 4'd1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_count", pass_count, 3);
    chk("ign_gos", go_cnt, 3);
    chk("ign_busy", busy, 0);
    chk("ign_pass", pass, 1);

    // Asynchronous reset in the middle of the n=7 request.
    clear_stats();
    pulse_start(4'd5, 4'd9);
    for (int i = 0; i < 200; i++) begin
      if (fact_go && fact_in == 4'd7) break;
      @(negedge clk);
    end
    chk("mid_at7", (fact_go && fact_in == 4'd7), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_go", fact_go, 0);
    chk("mid_in", fact_in, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pass", pass, 0);
    chk("mid_fail", fail, 0);
    chk("mid_cnt", pass_count, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_still_idle", busy, 0);
    clear_stats();
    pulse_start(4'd2, 4'd3);
    wait_done("post_wait");
    repeat (2) @(negedge clk);
    chk("post_pass", pass, 1);
    chk("post_fail", fail, 0);
    chk("post_count", pass_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
